// File: rtl/gtp_link_ctrl.sv
// SATA link bring-up/recovery sequencer: drives the OOB engine's StartComm, times out stalled
// negotiations with retry/back-off, debounces link_up and reports ready/drop/fail status.
module gtp_link_ctrl #(
    parameter int unsigned C_PULSE_CYC = 16,
    parameter logic [23:0] C_LINK_TMO  = 24'd1000000,
    parameter logic [23:0] C_BACKOFF   = 24'd4096,
    parameter int unsigned C_MAX_RETRY = 7,
    parameter int unsigned C_DEBOUNCE  = 8
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic       port_enable,
    input  logic       port_reset_req,
    input  logic       plllkdet,
    input  logic       tx_sync_done,
    input  logic       link_up,
    input  logic       CommInit,
    output logic       StartComm,
    output logic       link_ready,
    output logic       link_fail,
    output logic       link_drop,
    output logic [3:0] retry_cnt,
    output logic [2:0] ctrl_state
);

    typedef enum logic [2:0] {
        StOff      = 3'd0,
        StWaitPhy  = 3'd1,
        StPulse    = 3'd2,
        StWaitLink = 3'd3,
        StUp       = 3'd4,
        StBackoff  = 3'd5,
        StFail     = 3'd6
    } state_e;

    localparam logic [23:0] PulseLast   = 24'(C_PULSE_CYC - 1);
    localparam logic [23:0] TmoLast     = C_LINK_TMO - 24'd1;
    localparam logic [23:0] BackoffLast = C_BACKOFF - 24'd1;
    localparam logic [3:0]  MaxRetry    = 4'(C_MAX_RETRY);
    localparam logic [7:0]  DebCnt      = 8'(C_DEBOUNCE);

    state_e      state_q, state_d;
    logic [23:0] timer_q, timer_d;
    logic [7:0]  deb_q, deb_d;
    logic [3:0]  retry_q, retry_d;
    logic        pll_q;
    logic        start_q, ready_q, fail_q, drop_q, drop_d;
    logic        pll_fall;

    assign pll_fall = pll_q & ~plllkdet;

    always_comb begin
        state_d = state_q;
        timer_d = '0;
        deb_d   = '0;
        retry_d = retry_q;
        drop_d  = 1'b0;

        if (!port_enable) begin
            state_d = StOff;
        end else if (port_reset_req && (state_q != StOff)) begin
            state_d = StPulse;
            retry_d = '0;
        end else if (pll_fall && (state_q inside {StPulse, StWaitLink, StUp, StBackoff})) begin
            state_d = StWaitPhy;
        end else begin
            case (state_q)
                StOff: state_d = StWaitPhy;
                StWaitPhy: begin
                    if (plllkdet && tx_sync_done) state_d = StPulse;
                end
                StPulse: begin
                    timer_d = timer_q + 24'd1;
                    if (timer_q == PulseLast) state_d = StWaitLink;
                end
                StWaitLink: begin
                    timer_d = timer_q + 24'd1;
                    deb_d   = link_up ? deb_q + 8'd1 : 8'd0;
                    // Debounce completion takes precedence over a coincident timeout.
                    if (deb_d == DebCnt) begin
                        state_d = StUp;
                        retry_d = '0;
                    end else if (timer_q == TmoLast) begin
                        retry_d = (retry_q >= MaxRetry) ? MaxRetry : retry_q + 4'd1;
                        state_d = (retry_d == MaxRetry) ? StFail : StBackoff;
                    end
                end
                StBackoff: begin
                    timer_d = timer_q + 24'd1;
                    if (timer_q == BackoffLast) state_d = StWaitLink;
                end
                StUp: begin
                    if (!link_up || CommInit) begin
                        state_d = StPulse;
                        drop_d  = 1'b1;
                    end
                end
                StFail: state_d = StFail;
                default: state_d = StOff;
            endcase
        end

        // Every state entry starts its timer from zero.
        if (state_d != state_q) timer_d = '0;
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q <= StOff;
            timer_q <= '0;
            deb_q   <= '0;
            retry_q <= '0;
            pll_q   <= 1'b0;
            start_q <= 1'b1;
            ready_q <= 1'b0;
            fail_q  <= 1'b0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            deb_q   <= deb_d;
            retry_q <= retry_d;
            pll_q   <= plllkdet;
            start_q <= state_d inside {StOff, StWaitPhy, StPulse, StBackoff, StFail};
            ready_q <= (state_d == StUp);
            fail_q  <= (state_d == StFail);
            drop_q  <= drop_d;
        end
    end

    assign StartComm  = start_q;
    assign link_ready = ready_q;
    assign link_fail  = fail_q;
    assign link_drop  = drop_q;
    assign retry_cnt  = retry_q;
    assign ctrl_state = state_q;

endmodule

// File: tb/tb_gtp_link_ctrl.sv
// Self-checking bench for gtp_link_ctrl with shortened timeout/back-off and a behavioural
// model of link negotiation timing (debounce window, timeout/back-off schedule).
module tb_gtp_link_ctrl;

    localparam int TMO   = 200;
    localparam int BO    = 50;
    localparam int PULSE = 16;
    localparam int DEB   = 8;
    localparam int MAXR  = 7;

    logic       sys_clk;
    logic       sys_rst_n;
    logic       port_enable, port_reset_req, plllkdet, tx_sync_done, link_up, CommInit;
    logic       StartComm, link_ready, link_fail, link_drop;
    logic [3:0] retry_cnt;
    logic [2:0] ctrl_state;

    int errors = 0;
    int checks = 0;

    gtp_link_ctrl #(
        .C_PULSE_CYC(PULSE),
        .C_LINK_TMO (24'd200),
        .C_BACKOFF  (24'd50),
        .C_MAX_RETRY(MAXR),
        .C_DEBOUNCE (DEB)
    ) dut (
        .sys_clk       (sys_clk),
        .sys_rst_n     (sys_rst_n),
        .port_enable   (port_enable),
        .port_reset_req(port_reset_req),
        .plllkdet      (plllkdet),
        .tx_sync_done  (tx_sync_done),
        .link_up       (link_up),
        .CommInit      (CommInit),
        .StartComm     (StartComm),
        .link_ready    (link_ready),
        .link_fail     (link_fail),
        .link_drop     (link_drop),
        .retry_cnt     (retry_cnt),
        .ctrl_state    (ctrl_state)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic wait_state(input logic [2:0] target, input int budget);
        int n = 0;
        while (ctrl_state !== target && n < budget) begin
            tick();
            n++;
        end
        checks++;
        if (ctrl_state !== target) begin
            errors++;
            $display("FAIL wait_state: got state %0d expected %0d within %0d cycles",
                     ctrl_state, target, budget);
        end
    endtask

    // Counts consecutive StPulse cycles starting from an already-observed first one.
    task automatic measure_pulse(output int n, output int sc_low, output int drops);
        n = 1; sc_low = 0; drops = 0;
        while (ctrl_state === 3'd2 && n < 40) begin
            tick();
            if (ctrl_state === 3'd2) begin
                n++;
                if (StartComm !== 1'b1) sc_low++;
                if (link_drop !== 1'b0) drops++;
            end
        end
    endtask

    task automatic restart();
        link_up = 1'b0;
        port_reset_req = 1'b1;
        tick();
        port_reset_req = 1'b0;
        wait_state(3'd3, 40);
    endtask

    // Expected state/retry t cycles after entering WAIT_LINK with link_up held low.
    function automatic void neg_model(input int t, output int st, output int rt);
        int u, k;
        if (t < TMO) begin
            st = 3; rt = 0;
        end else begin
            u  = t - TMO;
            k  = 1 + u / (TMO + BO);
            rt = (k > MAXR) ? MAXR : k;
            if (k >= MAXR) st = 6;
            else st = ((u % (TMO + BO)) < BO) ? 5 : 3;
        end
    endfunction

    task automatic run_neg_model(input int tmax);
        int st, rt, bad, first;
        bad = 0; first = -1;
        for (int t = 0; t <= tmax; t++) begin
            if (t > 0) tick();
            neg_model(t, st, rt);
            if (ctrl_state !== 3'(st) || retry_cnt !== 4'(rt) ||
                StartComm !== (st == 5 || st == 6) || link_fail !== (st == 6)) begin
                if (bad == 0) first = t;
                bad++;
            end
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL neg_schedule: got %0d bad cycles (first at t=%0d) expected 0",
                     bad, first);
        end
    endtask

    task automatic test_reset();
        sys_rst_n = 1'b0;
        port_enable = 0; port_reset_req = 0; plllkdet = 0; tx_sync_done = 0;
        link_up = 0; CommInit = 0;
        #12;
        checks++;
        if ({StartComm, link_ready, link_fail, link_drop, retry_cnt, ctrl_state} !== 11'h400) begin
            errors++;
            $display("FAIL reset_outputs: got %h expected 400",
                     {StartComm, link_ready, link_fail, link_drop, retry_cnt, ctrl_state});
        end
        sys_rst_n = 1'b1;
        tick();
        checks++;
        if (ctrl_state !== 3'd0 || StartComm !== 1'b1) begin
            errors++;
            $display("FAIL disabled_idle: got state %0d sc %b expected 0 1", ctrl_state, StartComm);
        end
    endtask

    task automatic test_bringup();
        int n, sc_low, drops, bad;
        port_enable = 1; plllkdet = 1; tx_sync_done = 1;
        tick();
        checks++;
        if (ctrl_state !== 3'd1) begin
            errors++; $display("FAIL enter_wait_phy: got %0d expected 1", ctrl_state);
        end
        tick();
        measure_pulse(n, sc_low, drops);
        checks++;
        if (n != PULSE || sc_low != 0) begin
            errors++;
            $display("FAIL pulse_len: got %0d (sc low %0d) expected %0d", n, sc_low, PULSE);
        end
        checks++;
        if (ctrl_state !== 3'd3 || StartComm !== 1'b0) begin
            errors++;
            $display("FAIL enter_wait_link: got %0d sc %b expected 3 0", ctrl_state, StartComm);
        end
        repeat (100) tick();
        link_up = 1;
        bad = 0;
        for (int i = 0; i < DEB - 1; i++) begin
            tick();
            if (link_ready !== 1'b0 || ctrl_state !== 3'd3) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++; $display("FAIL early_ready: got %0d bad cycles expected 0", bad);
        end
        tick();
        checks++;
        if (link_ready !== 1'b1 || ctrl_state !== 3'd4 || retry_cnt !== 4'd0) begin
            errors++;
            $display("FAIL link_up_state: got rdy %b st %0d rc %0d expected 1 4 0",
                     link_ready, ctrl_state, retry_cnt);
        end
    endtask

    task automatic test_glitch();
        int bad = 0;
        restart();
        link_up = 1;
        repeat (7) begin tick(); if (link_ready !== 1'b0) bad++; end
        link_up = 0;
        tick(); if (link_ready !== 1'b0) bad++;
        link_up = 1;
        repeat (DEB - 1) begin tick(); if (link_ready !== 1'b0) bad++; end
        checks++;
        if (bad != 0) begin
            errors++; $display("FAIL glitch_premature: got %0d ready cycles expected 0", bad);
        end
        tick();
        checks++;
        if (link_ready !== 1'b1 || ctrl_state !== 3'd4) begin
            errors++;
            $display("FAIL glitch_ready: got %b st %0d expected 1 4", link_ready, ctrl_state);
        end
    endtask

    task automatic test_drop();
        int n, sc_low, drops;
        for (int v = 0; v < 2; v++) begin
            if (v == 0) link_up = 0; else CommInit = 1;
            tick();
            link_up = 1; CommInit = 0;
            checks++;
            if (ctrl_state !== 3'd2 || link_drop !== 1'b1 || StartComm !== 1'b1 ||
                link_ready !== 1'b0 || retry_cnt !== 4'd0) begin
                errors++;
                $display("FAIL drop_%0d: got st %0d drop %b sc %b rdy %b rc %0d expected 2 1 1 0 0",
                         v, ctrl_state, link_drop, StartComm, link_ready, retry_cnt);
            end
            measure_pulse(n, sc_low, drops);
            checks++;
            if (n != PULSE || sc_low != 0 || drops != 0) begin
                errors++;
                $display("FAIL drop_pulse_%0d: got len %0d sc low %0d drops %0d expected %0d 0 0",
                         v, n, sc_low, drops, PULSE);
            end
            wait_state(3'd4, 20);
            checks++;
            if (link_ready !== 1'b1 || retry_cnt !== 4'd0) begin
                errors++;
                $display("FAIL drop_relink_%0d: got rdy %b rc %0d expected 1 0",
                         v, link_ready, retry_cnt);
            end
        end
    endtask

    task automatic test_pll_loss();
        plllkdet = 0;
        tick();
        checks++;
        if (ctrl_state !== 3'd1 || link_ready !== 1'b0 || StartComm !== 1'b1) begin
            errors++;
            $display("FAIL pll_loss: got st %0d rdy %b sc %b expected 1 0 1",
                     ctrl_state, link_ready, StartComm);
        end
        plllkdet = 1;
        wait_state(3'd4, 40);
    endtask

    task automatic test_random();
        int hist[$];
        int lvl, rem, ones, exp_st, bad, done;
        for (int it = 0; it < 8; it++) begin
            restart();
            hist.delete();
            lvl = 0; rem = 0; bad = 0; done = 0; exp_st = 3;
            for (int i = 1; i <= TMO + 5 && done == 0; i++) begin
                if (rem == 0) begin
                    lvl = 1 - lvl;
                    rem = (lvl == 1) ? int'($urandom_range(1, 10)) : int'($urandom_range(1, 25));
                end
                link_up = lvl[0];
                rem--;
                hist.push_back(lvl);
                tick();
                ones = 0;
                if (hist.size() >= DEB)
                    for (int j = 0; j < DEB; j++) ones += hist[hist.size() - 1 - j];
                if (ones == DEB) begin exp_st = 4; done = 1; end
                else if (i == TMO) begin exp_st = 5; done = 1; end
                if (ctrl_state !== 3'(exp_st)) bad++;
            end
            checks++;
            if (bad != 0 || link_ready !== (exp_st == 4) ||
                retry_cnt !== ((exp_st == 5) ? 4'd1 : 4'd0)) begin
                errors++;
                $display("FAIL random_%0d: got bad %0d st %0d rdy %b rc %0d expected 0 %0d",
                         it, bad, ctrl_state, link_ready, retry_cnt, exp_st);
            end
        end
    endtask

    task automatic test_fail();
        restart();
        run_neg_model(TMO + 6 * (TMO + BO) + 60);
        checks++;
        if (ctrl_state !== 3'd6 || link_fail !== 1'b1 || retry_cnt !== 4'd7 ||
            StartComm !== 1'b1 || link_ready !== 1'b0) begin
            errors++;
            $display("FAIL fail_state: got st %0d lf %b rc %0d sc %b expected 6 1 7 1",
                     ctrl_state, link_fail, retry_cnt, StartComm);
        end
    endtask

    task automatic test_simultaneous();
        restart();
        run_neg_model(TMO + 6 * (TMO + BO) - 1);
        checks++;
        if (retry_cnt !== 4'd6 || ctrl_state !== 3'd3) begin
            errors++;
            $display("FAIL pre_simul: got rc %0d st %0d expected 6 3", retry_cnt, ctrl_state);
        end
        port_reset_req = 1;
        tick();
        port_reset_req = 0;
        checks++;
        if (ctrl_state !== 3'd2 || retry_cnt !== 4'd0 || link_fail !== 1'b0) begin
            errors++;
            $display("FAIL simul: got st %0d rc %0d lf %b expected 2 0 0",
                     ctrl_state, retry_cnt, link_fail);
        end
    endtask

    task automatic test_disable_reset();
        wait_state(3'd3, 40);
        repeat (5) tick();
        port_enable = 0;
        tick();
        checks++;
        if (ctrl_state !== 3'd0 || StartComm !== 1'b1) begin
            errors++;
            $display("FAIL disable: got st %0d sc %b expected 0 1", ctrl_state, StartComm);
        end
        port_enable = 1;
        wait_state(3'd3, 40);
        wait_state(3'd5, TMO + 10);
        repeat (10) tick();
        checks++;
        if (retry_cnt !== 4'd1 || ctrl_state !== 3'd5) begin
            errors++;
            $display("FAIL pre_reset: got rc %0d st %0d expected 1 5", retry_cnt, ctrl_state);
        end
        #2 sys_rst_n = 1'b0;
        #1;
        checks++;
        if ({StartComm, link_ready, link_fail, link_drop, retry_cnt, ctrl_state} !== 11'h400) begin
            errors++;
            $display("FAIL async_reset: got %h expected 400",
                     {StartComm, link_ready, link_fail, link_drop, retry_cnt, ctrl_state});
        end
        #10 sys_rst_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_bringup();
        test_glitch();
        test_drop();
        test_pll_loss();
        test_random();
        test_fail();
        test_simultaneous();
        test_disable_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
